// File: rtl/spi_debug_pkg.sv
// Shared types and defaults for the SPI debug bridge.
package spi_debug_pkg;

    // Frame-level states of the SPI slave.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDUMMY,
        ST_RDATA
    } frame_state_e;

    // Default build parameters.
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;
    localparam int DEF_STARTUP = 65535;
    localparam int DEF_SYNC    = 2;

    // The read/write select lives in the top bit of the command word.
    function automatic int cmd_read_bit(input int dw);
        return dw - 1;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronisers for the asynchronous SPI pins plus edge detection on SCLK.
module spi_pin_sync
    import spi_debug_pkg::*;
#(
    parameter int SYNC = DEF_SYNC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_i,
    input  logic spi_data_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_n_o,
    output logic mosi_o
);

    logic [SYNC-1:0] sclk_q, sclk_d;
    logic [SYNC-1:0] cs_q, cs_d;
    logic [SYNC-1:0] mosi_q, mosi_d;
    logic            sclk_prev_q, sclk_prev_d;

    // Shift each pin one stage deeper into the system clock domain.
    always_comb begin
        sclk_d      = {sclk_q[SYNC-2:0], spi_clk};
        cs_d        = {cs_q[SYNC-2:0], spi_cs_i};
        mosi_d      = {mosi_q[SYNC-2:0], spi_data_i};
        sclk_prev_d = sclk_q[SYNC-1];
    end

    // Synchroniser registers; chip select comes out of reset deasserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            cs_q        <= cs_d;
            mosi_q      <= mosi_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign sclk_rise_o = sclk_q[SYNC-1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[SYNC-1] & sclk_prev_q;
    assign cs_n_o      = cs_q[SYNC-1];
    assign mosi_o      = mosi_q[SYNC-1];

endmodule

// File: rtl/spi_debug_bridge.sv
// SPI slave that turns host frames into write/read bursts on the system bus.
module spi_debug_bridge
    import spi_debug_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int STARTUP = DEF_STARTUP,
    parameter int SYNC    = DEF_SYNC
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          spi_clk,
    input  logic          spi_cs_i,
    input  logic          spi_data_i,
    output logic          spi_data_o,
    output logic          bus_req_o,
    output logic          bus_wr_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_ack_i,
    output logic          overrun_o
);

    localparam int CW     = (STARTUP > 0) ? $clog2(STARTUP + 1) : 1;
    localparam int BW     = (DW > 1) ? $clog2(DW) : 1;
    localparam int RD_BIT = cmd_read_bit(DW);

    logic sclk_rise, sclk_fall, cs_n, mosi;

    spi_pin_sync #(.SYNC(SYNC)) u_pin_sync (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .spi_clk     (spi_clk),
        .spi_cs_i    (spi_cs_i),
        .spi_data_i  (spi_data_i),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_n_o      (cs_n),
        .mosi_o      (mosi)
    );

    frame_state_e  state_q, state_d;
    logic [CW-1:0] start_cnt_q, start_cnt_d;
    logic          cs_prev_q, cs_prev_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] shift_q, shift_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] miso_q, miso_d;
    logic          req_q, req_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] baddr_q, baddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          overrun_q, overrun_d;

    logic          ready, ack_now, busy, rd_avail;
    logic [DW-1:0] word, rd_word;
    logic          word_done, issue, issue_wr;
    logic [AW-1:0] issue_addr;
    logic [DW-1:0] issue_data;

    // An ack in the same cycle as a word completion frees the bus first.
    assign ready    = (start_cnt_q == CW'(STARTUP));
    assign word     = {mosi, shift_q[DW-1:1]};
    assign ack_now  = req_q & bus_ack_i;
    assign busy     = req_q & ~bus_ack_i;
    assign rd_avail = rvalid_q | (ack_now & ~wr_q);
    assign rd_word  = (ack_now & ~wr_q) ? bus_rdata_i : rdata_q;

    // Frame FSM, MISO shifter and bus request generation.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        cs_prev_d   = cs_n;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        miso_d      = miso_q;
        req_d       = req_q;
        wr_d        = wr_q;
        baddr_d     = baddr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
        issue       = 1'b0;
        issue_wr    = 1'b0;
        issue_addr  = '0;
        issue_data  = '0;

        if (!ready) begin
            start_cnt_d = start_cnt_q + CW'(1);
        end

        if (ack_now) begin
            req_d = 1'b0;
            if (!wr_q) begin
                rdata_d  = bus_rdata_i;
                rvalid_d = 1'b1;
            end
        end

        if (cs_n) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            miso_d    = '0;
        end else if (state_q == ST_IDLE) begin
            // Only a fresh CS falling edge opens a frame, never one already in progress.
            if (ready && cs_prev_q) begin
                state_d   = ST_CMD;
                bit_cnt_d = '0;
            end
        end else begin
            if (sclk_rise) begin
                shift_d = word;
                if (bit_cnt_q == BW'(DW - 1)) begin
                    bit_cnt_d = '0;
                    word_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            // The fall right after a word boundary still belongs to the old word.
            if (sclk_fall && bit_cnt_q != '0) begin
                miso_d = miso_q >> 1;
            end
            if (word_done) begin
                case (state_q)
                    ST_CMD: begin
                        if (word[RD_BIT]) begin
                            issue      = 1'b1;
                            issue_addr = word[AW-1:0];
                            addr_d     = word[AW-1:0] + AW'(1);
                            miso_d     = '0;
                            rvalid_d   = 1'b0;
                            state_d    = ST_RDUMMY;
                        end else begin
                            addr_d  = word[AW-1:0];
                            state_d = ST_WDATA;
                        end
                    end
                    ST_WDATA: begin
                        issue      = 1'b1;
                        issue_wr   = 1'b1;
                        issue_addr = addr_q;
                        issue_data = word;
                        addr_d     = addr_q + AW'(1);
                    end
                    ST_RDUMMY, ST_RDATA: begin
                        miso_d = rd_avail ? rd_word : '0;
                        if (!rd_avail) begin
                            overrun_d = 1'b1;
                        end
                        issue      = 1'b1;
                        issue_addr = addr_q;
                        addr_d     = addr_q + AW'(1);
                        rvalid_d   = 1'b0;
                        state_d    = ST_RDATA;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        if (issue) begin
            if (busy) begin
                overrun_d = 1'b1;
            end else begin
                req_d   = 1'b1;
                wr_d    = issue_wr;
                baddr_d = issue_addr;
                if (issue_wr) begin
                    wdata_d = issue_data;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            start_cnt_q <= '0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            miso_q      <= '0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            baddr_q     <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            miso_q      <= miso_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            baddr_q     <= baddr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign spi_data_o  = miso_q[0];
    assign bus_req_o   = req_q;
    assign bus_wr_o    = wr_q;
    assign bus_addr_o  = baddr_q;
    assign bus_wdata_o = wdata_q;
    assign overrun_o   = overrun_q;

endmodule
